sbox_pipe: RTL and testbench

- Parametrised, pipelined multi-lane AES S-box engine built on the composite-field GF((2^4)^2) datapath.
- Each lane is isomorphism → GF(2^4) products/square·v → GF(2^4) inverse → GF(2^4) multiplies → inverse isomorphism + affine.
- Shared by key expansion (SubWord, 4 lanes) and the round datapath (SubBytes, 16 lanes).
- Valid/ready handshake, one transaction per cycle, tag passthrough.

---
 rtl/sbox_pipe.sv | 197 +++++++++++++++++++
 tb/tb_sbox_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_pipe.sv
// Three-stage multi-lane AES S-box on a GF((2^4)^2) composite-field datapath with valid/ready flow control.
// Define SBOX_PIPE_INV_EN to add per-transaction inverse S-box selection through in_inv.
module sbox_pipe #(
  parameter int NUM_BYTES = 4,
  parameter int TAG_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic                   in_inv,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag
);
  localparam int W = 8 * NUM_BYTES;
  // Extension element Y satisfies Y^2 + Y + V = 0; V has trace 1 so this is irreducible over GF(16).
  localparam logic [3:0] V = 4'hE;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  // a^14 == a^-1 in GF(16), and maps 0 to 0 as the S-box requires
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_mul(a, a);
    a4 = gf4_mul(a2, a2);
    a8 = gf4_mul(a4, a4);
    return gf4_mul(gf4_mul(a8, a4), a2);
  endfunction

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  // Column k of m is the image of input bit k.
  function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (x[k]) r = r ^ m[8*k +: 8];
    end
    return r;
  endfunction

  // Elaboration-time derivation of both basis-change matrices: {GF(2^8)->composite, composite->GF(2^8)}.
  function automatic logic [127:0] build_maps();
    logic [7:0]  e, a, y, vp;
    logic [31:0] pw;
    logic [63:0] fwd, bwd;
    a = 8'h00;
    y = 8'h00;
    for (int c = 1; c < 256; c++) begin
      e = 8'(c);
      if ((gf8_mul(gf8_mul(e, e), gf8_mul(e, e)) ^ e ^ 8'h01) == 8'h00) a = e;
    end
    pw = {gf8_mul(gf8_mul(a, a), a), gf8_mul(a, a), a, 8'h01};
    vp = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (V[i]) vp = vp ^ pw[8*i +: 8];
    end
    for (int c = 1; c < 256; c++) begin
      e = 8'(c);
      if ((gf8_mul(e, e) ^ e ^ vp) == 8'h00) y = e;
    end
    for (int i = 0; i < 4; i++) begin
      fwd[8*i +: 8]     = pw[8*i +: 8];
      fwd[8*(i+4) +: 8] = gf8_mul(y, pw[8*i +: 8]);
    end
    bwd = '0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 256; c++) begin
        if (lin_map(fwd, 8'(c)) == (8'h01 << k)) bwd[8*k +: 8] = 8'(c);
      end
    end
    return {bwd, fwd};
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

  localparam logic [127:0] MAPS    = build_maps();
  localparam logic [63:0]  ISO     = MAPS[127:64];
  localparam logic [63:0]  INV_ISO = MAPS[63:0];

  logic                   stall;
  logic                   s1_valid, s2_valid;
  logic [TAG_W-1:0]       s1_tag, s2_tag;
  logic [W-1:0]           s1_data, s2_data;
  logic [4*NUM_BYTES-1:0] s2_dinv;
  logic [W-1:0]           s1_data_next, out_data_next;
  logic [4*NUM_BYTES-1:0] dinv_next;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

`ifdef SBOX_PIPE_INV_EN
  logic s1_inv, s2_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inv <= 1'b0;
      s2_inv <= 1'b0;
    end else if (!stall) begin
      s1_inv <= in_inv;
      s2_inv <= s1_inv;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    logic [7:0] s1_in, s3_lin;
    logic [3:0] g1, g0, hi, lo, dinv;

`ifdef SBOX_PIPE_INV_EN
    assign s1_in = in_inv ? inv_affine(in_data[8*gi +: 8]) : in_data[8*gi +: 8];
`else
    assign s1_in = in_data[8*gi +: 8];
`endif
    assign s1_data_next[8*gi +: 8] = lin_map(ISO, s1_in);

    assign g1 = s1_data[8*gi+4 +: 4];
    assign g0 = s1_data[8*gi +: 4];
    assign dinv_next[4*gi +: 4] = gf4_inv(gf4_mul(g1, g0) ^ gf4_mul(g0, g0) ^ gf4_mul(V, gf4_mul(g1, g1)));

    assign dinv   = s2_dinv[4*gi +: 4];
    assign hi     = gf4_mul(s2_data[8*gi+4 +: 4], dinv);
    assign lo     = gf4_mul(s2_data[8*gi+4 +: 4] ^ s2_data[8*gi +: 4], dinv);
    assign s3_lin = lin_map(INV_ISO, {hi, lo});
`ifdef SBOX_PIPE_INV_EN
    assign out_data_next[8*gi +: 8] = s2_inv ? s3_lin : affine(s3_lin);
`else
    assign out_data_next[8*gi +: 8] = affine(s3_lin);
`endif
  end

  // Whole pipe advances in lockstep; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_tag    <= '0;
      s2_tag    <= '0;
      out_tag   <= '0;
      s1_data   <= '0;
      s2_data   <= '0;
      s2_dinv   <= '0;
      out_data  <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_tag    <= in_tag;
      s1_data   <= s1_data_next;
      s2_valid  <= s1_valid;
      s2_tag    <= s1_tag;
      s2_data   <= s1_data;
      s2_dinv   <= dinv_next;
      out_valid <= s2_valid;
      out_tag   <= s2_tag;
      out_data  <= out_data_next;
    end
  end
endmodule

// File: tb/tb_sbox_pipe.sv
// Self-checking bench for sbox_pipe (4 lanes) against a field-arithmetic S-box model.
// Inverse-mode scenarios are built when SBOX_PIPE_INV_EN is defined.
module tb_sbox_pipe;
`ifdef SBOX_PIPE_INV_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_inv = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  int n_checks = 0;
  int n_err = 0;
  int cycle = 0;

  logic [7:0]  sbox_t[256];
  logic [7:0]  isbox_t[256];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_t[$];
  logic [31:0] got_d[$];
  logic [3:0]  got_t[$];
  int          got_c[$];
  int          acc_c[$];

  sbox_pipe #(.NUM_BYTES(4), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_c.push_back(cycle);
    if (rst_n && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_t.push_back(out_tag);
      got_c.push_back(cycle);
    end
    cycle <= cycle + 1;
  end

  // Model: multiplicative inverse in GF(2^8) by x^254, then the FIPS-197 bitwise affine formula.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] r, s;
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, 8'(x));
      if (x == 0) r = 8'h00;
      for (int i = 0; i < 8; i++)
        s[i] = r[i] ^ r[(i+4)%8] ^ r[(i+5)%8] ^ r[(i+6)%8] ^ r[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input bit inv);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = (INV_ON && inv) ? isbox_t[d[8*i +: 8]] : sbox_t[d[8*i +: 8]];
    return r;
  endfunction

  task automatic clear_q();
    exp_d.delete(); exp_t.delete(); got_d.delete(); got_t.delete(); got_c.delete(); acc_c.delete();
  endtask

  // Drive one transaction from a negedge; returns at the negedge after it is accepted.
  task automatic push(input logic [31:0] d, input logic [3:0] t, input bit inv, input logic [31:0] e);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_tag = t; in_inv = inv;
    exp_d.push_back(e); exp_t.push_back(t);
    forever begin
      @(posedge clk);
      if (in_ready) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 500) begin
        n_checks++; n_err++;
        $display("FAIL push_timeout got=no_accept required=accept_within_500");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    for (int w = 0; w < budget && got_d.size() < exp_d.size(); w++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got=%h required=0", out_data); end
    if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag got=%h required=0", out_tag); end
    in_valid = 1'b1; in_data = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid got=%b required=0", out_valid); end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release got=ready%b/valid%b required=ready1/valid0", in_ready, out_valid);
    end else $display("txn reset ok");
    repeat (5) @(negedge clk);
    n_checks++;
    if (got_d.size() != 0) begin n_err++; $display("FAIL reset_leak got=%0d outputs required=0", got_d.size()); end
    clear_q();
  endtask

  task automatic test_subword();
    clear_q();
    push(32'hCF4F3C09, 4'hA, 1'b0, 32'h8A84EB01);
    wait_out(20);
    n_checks += 2;
    if (got_d.size() != 1 || got_d[0] !== 32'h8A84EB01 || got_t[0] !== 4'hA) begin
      n_err++; $display("FAIL subword_data got=%h/%h (n=%0d) required=8a84eb01/a",
                        (got_d.size() > 0) ? got_d[0] : 32'h0, (got_t.size() > 0) ? got_t[0] : 4'h0, got_d.size());
    end else $display("txn subword data=%h tag=%h ok", got_d[0], got_t[0]);
    if (got_c.size() == 0 || acc_c.size() == 0 || got_c[0] - acc_c[0] != 3) begin
      n_err++; $display("FAIL subword_latency got=%0d required=3", (got_c.size() > 0 && acc_c.size() > 0) ? got_c[0] - acc_c[0] : -1);
    end
  endtask

  task automatic test_known_vectors();
    clear_q();
    push(32'hFF530100, 4'h5, 1'b0, 32'h16ED7C63);
    wait_out(20);
    n_checks++;
    if (got_d.size() != 1 || got_d[0] !== 32'h16ED7C63) begin
      n_err++; $display("FAIL known_vectors got=%h (n=%0d) required=16ed7c63", (got_d.size() > 0) ? got_d[0] : 32'h0, got_d.size());
    end else $display("txn known_vectors data=%h ok", got_d[0]);
  endtask

  task automatic test_exhaustive();
    logic [31:0] d;
    clear_q();
    for (int i = 0; i < 256; i++) begin
      d = {8'($urandom), 8'($urandom), 8'($urandom), 8'(i)};
      push(d, 4'($urandom), 1'b0, model(d, 1'b0));
    end
    wait_out(400);
    for (int i = 0; i < exp_d.size(); i++) begin
      n_checks++;
      if (i >= got_d.size()) begin
        n_err++; $display("FAIL exhaustive_missing idx=%0d got=none required=%h", i, exp_d[i]);
      end else if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
        n_err++; $display("FAIL exhaustive_data idx=%0d got=%h/%h required=%h/%h", i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
      end else $display("txn exhaustive %0d data=%h tag=%h ok", i, got_d[i], got_t[i]);
    end
    n_checks++;
    if (got_c.size() != 256 || got_c[255] - got_c[0] != 255 || got_c[0] - acc_c[0] != 3) begin
      n_err++; $display("FAIL exhaustive_timing got=n%0d required=n256_consecutive_latency3", got_c.size());
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    out_ready = 1'b1;
    fork
      begin
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
          d = $urandom;
          push(d, 4'(i), 1'b0, model(d, 1'b0));
        end
      end
      begin
        int w = 0;
        logic [31:0] hold_d;
        logic [3:0]  hold_t;
        while (!out_valid && w < 50) begin @(negedge clk); w++; end
        n_checks++;
        if (!out_valid) begin n_err++; $display("FAIL bp_no_output got=0 required=out_valid"); end
        out_ready = 1'b0; hold_d = out_data; hold_t = out_tag;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== hold_d || out_tag !== hold_t) begin
            n_err++; $display("FAIL bp_stall cyc=%0d got=rdy%b/v%b/%h/%h required=rdy0/v1/%h/%h",
                              k, in_ready, out_valid, out_data, out_tag, hold_d, hold_t);
          end
        end
        out_ready = 1'b1;
      end
    join
    wait_out(50);
    for (int i = 0; i < exp_d.size(); i++) begin
      n_checks++;
      if (i >= got_d.size()) begin
        n_err++; $display("FAIL bp_missing idx=%0d got=none required=%h", i, exp_d[i]);
      end else if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
        n_err++; $display("FAIL bp_data idx=%0d got=%h/%h required=%h/%h", i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
      end else $display("txn backpressure %0d data=%h tag=%h ok", i, got_d[i], got_t[i]);
    end
    n_checks++;
    if (got_d.size() != 8) begin n_err++; $display("FAIL bp_count got=%0d required=8", got_d.size()); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    clear_q();
    for (int i = 0; i < 3; i++) push($urandom, 4'(i + 1), 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || got_d.size() != 0) begin
      n_err++; $display("FAIL midreset_clear got=v%b/%h/%h/n%0d required=v0/0/0/n0", out_valid, out_data, out_tag, got_d.size());
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    repeat (6) @(negedge clk);
    n_checks++;
    if (got_d.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_stale got=n%0d/v%b required=n0/v0", got_d.size(), out_valid);
    end
    d = $urandom;
    push(d, 4'hC, 1'b0, model(d, 1'b0));
    wait_out(20);
    n_checks++;
    if (got_d.size() != 1 || got_d[0] !== exp_d[0] || got_t[0] !== 4'hC || got_c[0] - acc_c[0] != 3) begin
      n_err++; $display("FAIL midreset_next got=%h (n=%0d) required=%h tag c latency 3",
                        (got_d.size() > 0) ? got_d[0] : 32'h0, got_d.size(), exp_d[0]);
    end else $display("txn midreset_next data=%h ok", got_d[0]);
  endtask

  task automatic test_random();
    bit done = 1'b0;
    clear_q();
    fork
      begin
        logic [31:0] d;
        bit inv;
        for (int i = 0; i < 120; i++) begin
          d = $urandom; inv = 1'($urandom);
          if ($urandom_range(0, 4) == 0) @(negedge clk);
          push(d, 4'($urandom), inv, model(d, inv));
        end
        for (int w = 0; w < 1000 && got_d.size() < exp_d.size(); w++) @(negedge clk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    for (int i = 0; i < exp_d.size(); i++) begin
      n_checks++;
      if (i >= got_d.size()) begin
        n_err++; $display("FAIL random_missing idx=%0d got=none required=%h", i, exp_d[i]);
      end else if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
        n_err++; $display("FAIL random_data idx=%0d got=%h/%h required=%h/%h", i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
      end else $display("txn random %0d data=%h tag=%h ok", i, got_d[i], got_t[i]);
    end
    n_checks++;
    if (got_d.size() != exp_d.size()) begin n_err++; $display("FAIL random_count got=%0d required=%0d", got_d.size(), exp_d.size()); end
  endtask

`ifdef SBOX_PIPE_INV_EN
  task automatic test_inverse();
    logic [7:0] vin [6] = '{8'h53, 8'hED, 8'h00, 8'h63, 8'hFF, 8'h16};
    logic [7:0] vout[6] = '{8'hED, 8'h53, 8'h63, 8'h00, 8'h16, 8'hFF};
    logic [31:0] d;
    logic [7:0]  x;
    clear_q();
    for (int i = 0; i < 6; i++) push({4{vin[i]}}, 4'(i), 1'(i % 2), {4{vout[i]}});
    for (int i = 0; i < 256; i++) begin
      x = 8'($urandom);
      d = {sbox_t[x], sbox_t[8'(255 - i)], sbox_t[x ^ 8'h5A], sbox_t[i]};
      push(d, 4'($urandom), 1'b1, {x, 8'(255 - i), x ^ 8'h5A, 8'(i)});
    end
    wait_out(400);
    for (int i = 0; i < exp_d.size(); i++) begin
      n_checks++;
      if (i >= got_d.size()) begin
        n_err++; $display("FAIL inverse_missing idx=%0d got=none required=%h", i, exp_d[i]);
      end else if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
        n_err++; $display("FAIL inverse_data idx=%0d got=%h/%h required=%h/%h", i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
      end else $display("txn inverse %0d data=%h tag=%h ok", i, got_d[i], got_t[i]);
    end
  endtask
`else
  task automatic test_macro_off();
    clear_q();
    push(32'h00000000, 4'h3, 1'b1, 32'h63636363);
    wait_out(20);
    n_checks++;
    if (got_d.size() != 1 || got_d[0] !== 32'h63636363 || got_t[0] !== 4'h3) begin
      n_err++; $display("FAIL macro_off got=%h (n=%0d) required=63636363",
                        (got_d.size() > 0) ? got_d[0] : 32'h0, got_d.size());
    end else $display("txn macro_off data=%h ok", got_d[0]);
  endtask
`endif

  initial begin
    build_tables();
    test_reset();
    test_subword();
    test_known_vectors();
    test_exhaustive();
    test_backpressure();
    test_reset_midflight();
    test_random();
`ifdef SBOX_PIPE_INV_EN
    test_inverse();
`else
    test_macro_off();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
